// File: rtl/collatz_host_driver.sv
// Host-side initiator for the Collatz chip pin protocol: writes a seed, starts COMPUTE, waits, reads results.
// One job at a time (~19 cycles plus compute time); start is ignored unless ready, with no queuing.
module collatz_host_driver #(
  parameter int START_TIMEOUT   = 16,
  parameter int COMPUTE_TIMEOUT = 65536
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] seed,
  output logic        ready,
  output logic        done,
  output logic [31:0] orbit_len,
  output logic [31:0] path_record,
  output logic        overflow,
  output logic        timeout,
  output logic [7:0]  dut_ui_in,
  output logic [7:0]  dut_uio_in,
  input  logic [7:0]  dut_uo_out,
  input  logic [7:0]  dut_uio_out,
  input  logic [7:0]  dut_uio_oe
);

  localparam int MAX_TO = (START_TIMEOUT > COMPUTE_TIMEOUT) ? START_TIMEOUT : COMPUTE_TIMEOUT;
  localparam int CW     = $clog2(MAX_TO + 1);
  localparam logic [CW-1:0] START_LAST   = CW'(START_TIMEOUT - 1);
  localparam logic [CW-1:0] COMPUTE_LAST = CW'(COMPUTE_TIMEOUT - 1);
  localparam logic [31:0]   OVF_MARK     = 32'hBAADF00D;

  typedef enum logic [2:0] {IDLE, WR, ARM, GO, WAIT_ON, WAIT_OFF, RD, FIN} state_t;

  state_t        state;
  logic [31:0]   seed_q;
  logic [3:0]    idx;
  logic [CW-1:0] cnt;
  logic [3:0]    idx_nx;
  logic [2:0]    rd_j;
  logic          computing;
  logic          unused_pins;

  assign idx_nx      = idx + 4'd1;
  assign rd_j        = 3'(idx - 4'd1);
  assign computing   = dut_uio_oe[7];
  assign unused_pins = ^{dut_uio_out, dut_uio_oe[6:0]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      seed_q      <= 32'h0;
      idx         <= 4'd0;
      cnt         <= '0;
      ready       <= 1'b1;
      done        <= 1'b0;
      orbit_len   <= 32'h0;
      path_record <= 32'h0;
      overflow    <= 1'b0;
      timeout     <= 1'b0;
      dut_ui_in   <= 8'h00;
      dut_uio_in  <= 8'h00;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            seed_q     <= seed;
            ready      <= 1'b0;
            timeout    <= 1'b0;
            overflow   <= 1'b0;
            idx        <= 4'd0;
            dut_ui_in  <= seed[7:0];
            dut_uio_in <= 8'h80;
            state      <= WR;
          end
        end
        WR: begin
          if (idx == 4'd3) begin
            dut_ui_in  <= 8'h00;
            dut_uio_in <= 8'h00;
            state      <= ARM;
          end else begin
            idx        <= idx_nx;
            dut_ui_in  <= seed_q[{idx_nx[1:0], 3'b000} +: 8];
            dut_uio_in <= {1'b1, 5'b00000, idx_nx[1:0]};
          end
        end
        ARM: begin
          dut_uio_in <= 8'h40;
          state      <= GO;
        end
        GO: begin
          dut_uio_in <= 8'h00;
          cnt        <= '0;
          state      <= WAIT_ON;
        end
        // A single-cycle COMPUTE (seed 2) must still move us on, so the check is every cycle.
        WAIT_ON: begin
          if (computing) begin
            cnt   <= '0;
            state <= WAIT_OFF;
          end else if (cnt == START_LAST) begin
            timeout <= 1'b1;
            state   <= FIN;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_OFF: begin
          if (!computing) begin
            idx        <= 4'd0;
            dut_uio_in <= 8'h00;
            state      <= RD;
          end else if (cnt == COMPUTE_LAST) begin
            timeout <= 1'b1;
            state   <= FIN;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        // Pipelined reads: address idx goes out each cycle, its byte lands two edges later.
        RD: begin
          if (idx < 4'd7) begin
            dut_uio_in <= {3'b000, idx_nx[2], 2'b00, idx_nx[1:0]};
          end else begin
            dut_uio_in <= 8'h00;
          end
          if (idx != 4'd0) begin
            if (rd_j[2]) begin
              path_record[{rd_j[1:0], 3'b000} +: 8] <= dut_uo_out;
            end else begin
              orbit_len[{rd_j[1:0], 3'b000} +: 8] <= dut_uo_out;
            end
          end
          if (idx == 4'd8) begin
            state <= FIN;
          end
          idx <= idx_nx;
        end
        FIN: begin
          dut_ui_in  <= 8'h00;
          dut_uio_in <= 8'h00;
          done       <= 1'b1;
          ready      <= 1'b1;
          overflow   <= !timeout && (path_record == OVF_MARK);
          state      <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_collatz_host_driver.sv
// Bench for collatz_host_driver: behavioural chip model on the pins, per-job reference model and
// scoreboard checked whenever done pulses.
module tb_collatz_host_driver;

  localparam int ST = 16;
  localparam int CT = 65536;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] seed = 32'h0;
  logic        ready, done, overflow, timeout;
  logic [31:0] orbit_len, path_record;
  logic [7:0]  dut_ui_in, dut_uio_in, dut_uo_out, dut_uio_out, dut_uio_oe;

  always #5 clk = ~clk;

  collatz_host_driver #(.START_TIMEOUT(ST), .COMPUTE_TIMEOUT(CT)) dut (
    .clk(clk), .reset(reset), .start(start), .seed(seed),
    .ready(ready), .done(done), .orbit_len(orbit_len), .path_record(path_record),
    .overflow(overflow), .timeout(timeout),
    .dut_ui_in(dut_ui_in), .dut_uio_in(dut_uio_in),
    .dut_uo_out(dut_uo_out), .dut_uio_out(dut_uio_out), .dut_uio_oe(dut_uio_oe)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", nm, act, expv);
    end
  endtask

  // ---------------- chip model: one Collatz step per COMPUTE cycle ----------------
  int          cyc = 0;
  int          go_edge = 0;
  logic [31:0] go_seed = 0;
  logic [31:0] c_seed, c_x, c_orb, c_path, nx;
  logic        c_comp, c_dead;
  logic [7:0]  c_uo;

  assign dut_uo_out  = c_uo;
  assign dut_uio_oe  = {c_comp, 7'b0};
  assign dut_uio_out = {c_comp, 7'b0};

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset) begin
      c_seed <= 0; c_x <= 0; c_orb <= 0; c_path <= 0;
      c_comp <= 0; c_dead <= 0; c_uo <= 0;
    end else begin
      if (dut_uio_in[7]) c_seed[{dut_uio_in[1:0], 3'b000} +: 8] <= dut_ui_in;
      c_uo <= dut_uio_in[4] ? c_path[{dut_uio_in[1:0], 3'b000} +: 8]
                            : c_orb[{dut_uio_in[1:0], 3'b000} +: 8];
      if (dut_uio_in[6]) begin
        go_edge <= cyc + 1;
        go_seed <= c_seed;
        if (!c_comp && !c_dead) begin
          c_comp <= 1; c_x <= c_seed; c_path <= c_seed;
        end
      end else if (c_comp) begin
        if (c_x[0] && c_x > 32'h55555554) begin
          c_path <= 32'hBAADF00D; c_dead <= 1; c_comp <= 0;
        end else begin
          nx = c_x[0] ? c_x * 3 + 1 : c_x >> 1;
          c_x <= nx;
          c_orb <= c_orb + 1;
          if (nx > c_path) c_path <= nx;
          if (nx == 1) c_comp <= 0;
        end
      end
    end
  end

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] seed;
    bit          tmo;
    bit          ck_orb;
    bit          ck_path;
    logic [31:0] orb;
    logic [31:0] path;
    bit          ovf;
    int          kind;   // 0 none, 1 start timeout, 2 compute timeout
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] m_acc = 0;
  bit          m_dead = 0;

  task automatic ref_run(input logic [31:0] s, output int steps, output longint mx,
                         output bit ovf, output bit hang);
    longint v;
    v = s; mx = s; steps = 0; ovf = 0; hang = (s == 0);
    while (!hang && !ovf && (steps == 0 || v != 1)) begin
      if (v % 2 == 1) v = 3 * v + 1;
      else v = v / 2;
      if (v > 64'hFFFF_FFFF) ovf = 1;
      else begin
        steps++;
        if (v > mx) mx = v;
        if (steps >= 100000) hang = 1;
      end
    end
  endtask

  task automatic model_job(input logic [31:0] s, output exp_t e);
    int steps; longint mx; bit ovf, hang;
    e.seed = s; e.tmo = 0; e.ck_orb = 0; e.ck_path = 0;
    e.orb = 0; e.path = 0; e.ovf = 0; e.kind = 0;
    if (m_dead) begin
      e.tmo = 1; e.kind = 1;
      return;
    end
    ref_run(s, steps, mx, ovf, hang);
    if (hang) begin
      e.tmo = 1; e.kind = 2;
    end else if (ovf) begin
      e.path = 32'hBAADF00D; e.ck_path = 1; e.ovf = 1; m_dead = 1;
    end else begin
      m_acc = m_acc + 32'(steps);
      e.orb = m_acc; e.path = mx[31:0]; e.ck_orb = 1; e.ck_path = 1;
    end
  endtask

  // ---------------- compare process ----------------
  int dones = 0;
  int tmo_edge = 0;
  bit prev_done = 0, prev_tmo = 0;

  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (timeout && !prev_tmo) tmo_edge = cyc;
      if (done) begin
        dones++;
        chk("done_width", prev_done, 0);
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_done: done=1, required no done (no job outstanding)");
        end else begin
          e = exp_q.pop_front();
          chk("ready_at_done", ready, 1);
          chk("written_seed", go_seed, e.seed);
          chk("timeout", timeout, e.tmo);
          chk("overflow", overflow, e.ovf);
          if (e.ck_orb)  chk("orbit_len", orbit_len, e.orb);
          if (e.ck_path) chk("path_record", path_record, e.path);
          if (e.kind == 1) chk("start_timeout_latency", tmo_edge - go_edge, ST);
          if (e.kind == 2) chk("compute_timeout_latency", tmo_edge - go_edge, CT + 1);
        end
      end
    end
    prev_done = done;
    prev_tmo  = timeout;
  end

  // ---------------- stimulus ----------------
  task automatic do_reset();
    @(negedge clk);
    reset = 1; start = 0;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    exp_q.delete(); m_acc = 0; m_dead = 0;
  endtask

  task automatic run_job(input logic [31:0] s, input bit pins, input bit noise);
    exp_t e; int budget; logic [15:0] w;
    budget = 0;
    while (!ready && budget < 100) begin @(negedge clk); budget++; end
    if (!ready) begin
      n_checks++; n_fail++;
      $display("FAIL ready_wait: ready=%0b, required 1", ready);
      return;
    end
    model_job(s, e);
    exp_q.push_back(e);
    start = 1; seed = s;
    @(posedge clk); #1 start = 0;
    if (noise) seed = $urandom;
    if (pins) begin
      for (int i = 0; i < 7; i++) begin
        @(negedge clk);
        if (i < 4) w = {6'b100000, i[1:0], s[8*i +: 8]};
        else if (i == 5) w = 16'h4000;
        else w = 16'h0000;
        chk($sformatf("pins_%0d", i), {dut_uio_in, dut_ui_in}, w);
      end
    end
    if (noise) begin
      @(negedge clk);
      if (!ready) begin
        start = 1; seed = $urandom;
        @(posedge clk); #1 start = 0;
      end
    end
    budget = 0;
    do begin @(negedge clk); budget++; end while (!done && budget < 70000);
    if (!done) begin
      n_checks++; n_fail++;
      $display("FAIL done_wait: done=%0b after %0d cycles, required 1", done, budget);
      exp_q.delete();
    end
  endtask

  initial begin
    int steps; longint mx; bit ovf, hang; int budget, d0;

    do_reset();
    @(negedge clk);
    chk("rst_ready", ready, 1);
    chk("rst_done", done, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_orbit", orbit_len, 0);
    chk("rst_path", path_record, 0);
    chk("rst_pins", {dut_uio_in, dut_ui_in}, 0);

    ref_run(3, steps, mx, ovf, hang); chk("model3_steps", steps, 7);  chk("model3_max", mx, 16);
    ref_run(2, steps, mx, ovf, hang); chk("model2_steps", steps, 1);  chk("model2_max", mx, 2);
    ref_run(7, steps, mx, ovf, hang); chk("model7_steps", steps, 16); chk("model7_max", mx, 52);

    run_job(3, 1, 0);
    chk("seed3_orbit", orbit_len, 7); chk("seed3_path", path_record, 16);
    chk("seed3_ovf", overflow, 0);    chk("seed3_tmo", timeout, 0);

    do_reset();
    run_job(2, 0, 0);
    chk("seed2_orbit", orbit_len, 1); chk("seed2_path", path_record, 2);

    do_reset();
    run_job(1, 0, 0);
    chk("seed1_orbit", orbit_len, 3); chk("seed1_path", path_record, 4);
    run_job(7, 0, 0);
    chk("seed7_orbit", orbit_len, 19); chk("seed7_path", path_record, 52);

    do_reset();
    for (int j = 0; j < 30; j++) begin
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 4)) @(negedge clk);
      run_job($urandom_range(1, 2000), 0, 1);
    end

    // reset while the chip is busy computing
    while (!ready) @(negedge clk);
    start = 1; seed = 27;
    @(posedge clk); #1 start = 0;
    budget = 0;
    do begin @(negedge clk); budget++; end while (!dut_uio_oe[7] && budget < 40);
    chk("oe_seen", dut_uio_oe[7], 1);
    repeat (5) @(negedge clk);
    reset = 1;
    @(posedge clk); #1 reset = 0;
    exp_q.delete(); m_acc = 0; m_dead = 0;
    @(negedge clk);
    chk("midrst_ready", ready, 1);
    chk("midrst_pins", {dut_uio_in, dut_ui_in}, 0);
    chk("midrst_done", done, 0);
    d0 = dones;
    repeat (300) @(negedge clk);
    chk("midrst_no_done", dones, d0);

    do_reset();
    run_job(32'hFFFF_FFFF, 0, 0);
    chk("ovf_path", path_record, 32'hBAADF00D); chk("ovf_flag", overflow, 1);
    run_job(3, 0, 0);
    chk("dead_tmo", timeout, 1); chk("dead_ovf", overflow, 0);

    do_reset();
    run_job(0, 0, 0);
    chk("seed0_tmo", timeout, 1);
    @(negedge clk);
    chk("seed0_ready", ready, 1);

    chk("jobs_left", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

endmodule
